// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank.
// Double-buffered digit value, per-slot blanking gap, active-low enables.
module seg_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   lz_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [3:0]              bin_data,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    dp_n,
  output logic                    frame_start
);

  localparam int unsigned   CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned   IW        = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_active;

  logic                  w_wrap;
  logic                  w_xfer;
  logic [CW-1:0]         w_cnt_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic [3:0]            w_nib;
  logic [NUM_DIGITS-1:0] w_sel_on;
  logic                  w_lz;

  always_comb begin
    w_wrap    = (r_cnt == CNT_MAX);
    w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
    w_idx_nxt = r_idx;
    if (w_wrap) begin
      w_idx_nxt = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end
    w_xfer   = en && w_wrap && (r_idx == IDX_MAX);
    w_nib    = r_active[{r_idx, 2'b00} +: 4];
    w_sel_on = ~(NUM_DIGITS'(1) << r_idx);
    w_lz     = lz_mask[r_idx] && (w_nib == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= BLANK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_active    <= '0;
      bin_data    <= '0;
      digit_sel_n <= '1;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (load) begin
        r_shadow <= digits_in;
      end
      // A load landing on the slot-0 transfer edge bypasses the shadow.
      if (w_xfer) begin
        r_active <= load ? digits_in : r_shadow;
      end

      if (en) begin
        r_cnt       <= w_cnt_nxt;
        r_idx       <= w_idx_nxt;
        r_state     <= (w_cnt_nxt < BLANK_END) ? BLANK : SHOW;
        bin_data    <= w_nib;
        frame_start <= w_xfer;
        if ((r_state == SHOW) && !w_lz) begin
          digit_sel_n <= w_sel_on;
          dp_n        <= ~dp_mask[r_idx];
        end else begin
          digit_sel_n <= '1;
          dp_n        <= 1'b1;
        end
      end else begin
        digit_sel_n <= '1;
        dp_n        <= 1'b1;
        frame_start <= 1'b0;
      end
    end
  end

endmodule
